// File: rtl/gray_frame_streamer.sv
// gray_frame_streamer: paces a full grayscale frame from a pixel source to a
// pixel sink, one read every PACE cycles, applying a selectable per-pixel op
// (pass / invert / threshold) in a two-stage registered pipeline.
module gray_frame_streamer #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 8,
    parameter int PACE  = 2,
    // Coordinate widths never drop below one bit, so a single-line frame still
    // gets a legal y port.
    parameter int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    parameter int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] thresh,
    input  logic [PIX_W-1:0] gray_in,
    output logic             read_enable,
    output logic [XW-1:0]    x_cnt,
    output logic [YW-1:0]    y_cnt,
    output logic             write_enable,
    output logic [PIX_W-1:0] gray_out,
    output logic             busy,
    output logic             conv_finished
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int NPIX = IMG_W * IMG_H;
    localparam int WCW  = $clog2(NPIX + 1);
    localparam int PW   = (PACE > 1) ? $clog2(PACE) : 1;

    localparam logic [XW-1:0]  X_LAST    = XW'(IMG_W - 1);
    localparam logic [YW-1:0]  Y_LAST    = YW'(IMG_H - 1);
    localparam logic [PW-1:0]  PACE_LAST = PW'(PACE - 1);
    localparam logic [WCW-1:0] WR_LAST   = WCW'(NPIX - 1);

    logic [1:0]       r_state;
    logic [PW-1:0]    r_pace;
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic             r_rdD1;
    logic             r_wrEn;
    logic [PIX_W-1:0] r_grayOut;
    logic [WCW-1:0]   r_wrCnt;
    logic [1:0]       r_mode;
    logic [PIX_W-1:0] r_thresh;

    logic             w_readEn;
    logic             w_startAccept;
    logic             w_lastRead;
    logic             w_lastWrite;
    logic [PIX_W-1:0] w_opResult;

    assign w_readEn      = (r_state == S_RUN) && (r_pace == '0);
    assign w_startAccept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_lastRead    = w_readEn && (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_lastWrite   = r_wrEn && (r_wrCnt == WR_LAST);

    assign read_enable   = w_readEn;
    assign x_cnt         = r_x;
    assign y_cnt         = r_y;
    assign write_enable  = r_wrEn;
    assign gray_out      = r_grayOut;
    assign busy          = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign conv_finished = (r_state == S_DONE);

    // Frame sequencer: a start only counts from IDLE or DONE; RUN ends on the
    // last read issued, DRAIN ends on the last write leaving the pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (w_startAccept) r_state <= S_RUN;
                S_RUN:          if (w_lastRead)    r_state <= S_DRAIN;
                S_DRAIN:        if (w_lastWrite)   r_state <= S_DONE;
                default:                           r_state <= S_IDLE;
            endcase
        end
    end

    // Op select and threshold are captured when a frame starts so the whole
    // frame is processed with one consistent setting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode   <= 2'd0;
            r_thresh <= '0;
        end else if (w_startAccept) begin
            r_mode   <= mode;
            r_thresh <= thresh;
        end
    end

    // Pace counter cycles 0..PACE-1 while reading; a read is issued at 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pace <= '0;
        end else if ((r_state == S_RUN) && !w_lastRead) begin
            r_pace <= (r_pace == PACE_LAST) ? '0 : r_pace + PW'(1);
        end else begin
            r_pace <= '0;
        end
    end

    // Raster coordinates of the next read; they wrap back to 0,0 after the
    // final pixel so they rest at the origin outside of a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_startAccept) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_readEn) begin
            if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    // Per-pixel operation on the source data, evaluated with the latched
    // frame settings.
    always_comb begin
        w_opResult = gray_in;
        case (r_mode)
            2'd1:    w_opResult = ~gray_in;
            2'd2:    w_opResult = (gray_in >= r_thresh) ? '1 : '0;
            default: w_opResult = gray_in;
        endcase
    end

    // Two-stage pipeline: the source answers one cycle after the read strobe,
    // and the processed pixel is registered out one cycle after that.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdD1    <= 1'b0;
            r_wrEn    <= 1'b0;
            r_grayOut <= '0;
        end else begin
            r_rdD1 <= w_readEn;
            r_wrEn <= r_rdD1;
            if (r_rdD1) begin
                r_grayOut <= w_opResult;
            end
        end
    end

    // Write counter: the frame is complete once every pixel has been written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrCnt <= '0;
        end else if (w_startAccept) begin
            r_wrCnt <= '0;
        end else if (r_wrEn) begin
            r_wrCnt <= r_wrCnt + WCW'(1);
        end
    end

endmodule

// File: tb/tb_gray_frame_streamer.sv
// tb_gray_frame_streamer: drives three differently sized streamer instances
// and predicts every output cycle by cycle from the frame timing rules.
module tb_gray_frame_streamer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] thresh;
    logic [15:0] gin;
    int          sel;

    logic        start0, start1, start2;
    logic        re0, re1, re2;
    logic [1:0]  x0, y0, x1, y1;
    logic [0:0]  x2, y2;
    logic        we0, we1, we2;
    logic [7:0]  go0, go1;
    logic [9:0]  go2;
    logic        busy0, busy1, busy2;
    logic        cf0, cf1, cf2;

    int oRe, oX, oY, oWe, oGo, oBusy, oCf;

    int checks;
    int errors;
    int lastOut [3];

    logic [15:0] pix    [16];
    logic [15:0] expOut [16];

    typedef struct {
        int          cfg;
        logic [1:0]  md;
        logic [15:0] th;
        logic [15:0] pin;
        logic [15:0] res;
    } vec_t;

    vec_t vecs [10];

    // Free-running clock.
    always #5 clk = ~clk;

    // Only the selected instance sees the start pulse; the others stay parked.
    assign start0 = start && (sel == 0);
    assign start1 = start && (sel == 1);
    assign start2 = start && (sel == 2);

    gray_frame_streamer #(.IMG_W(4), .IMG_H(3), .PIX_W(8), .PACE(1), .XW(2), .YW(2)) u_p1 (
        .clk(clk), .reset_n(reset_n), .start(start0), .mode(mode), .thresh(thresh[7:0]),
        .gray_in(gin[7:0]), .read_enable(re0), .x_cnt(x0), .y_cnt(y0),
        .write_enable(we0), .gray_out(go0), .busy(busy0), .conv_finished(cf0));

    gray_frame_streamer #(.IMG_W(4), .IMG_H(3), .PIX_W(8), .PACE(3), .XW(2), .YW(2)) u_p3 (
        .clk(clk), .reset_n(reset_n), .start(start1), .mode(mode), .thresh(thresh[7:0]),
        .gray_in(gin[7:0]), .read_enable(re1), .x_cnt(x1), .y_cnt(y1),
        .write_enable(we1), .gray_out(go1), .busy(busy1), .conv_finished(cf1));

    gray_frame_streamer #(.IMG_W(2), .IMG_H(1), .PIX_W(10), .PACE(1), .XW(1), .YW(1)) u_w10 (
        .clk(clk), .reset_n(reset_n), .start(start2), .mode(mode), .thresh(thresh[9:0]),
        .gray_in(gin[9:0]), .read_enable(re2), .x_cnt(x2), .y_cnt(y2),
        .write_enable(we2), .gray_out(go2), .busy(busy2), .conv_finished(cf2));

    // Route the selected instance's outputs onto one set of observation vars.
    always_comb begin
        oRe = 0; oX = 0; oY = 0; oWe = 0; oGo = 0; oBusy = 0; oCf = 0;
        case (sel)
            0: begin
                oRe = int'(re0); oX = int'(x0); oY = int'(y0); oWe = int'(we0);
                oGo = int'(go0); oBusy = int'(busy0); oCf = int'(cf0);
            end
            1: begin
                oRe = int'(re1); oX = int'(x1); oY = int'(y1); oWe = int'(we1);
                oGo = int'(go1); oBusy = int'(busy1); oCf = int'(cf1);
            end
            default: begin
                oRe = int'(re2); oX = int'(x2); oY = int'(y2); oWe = int'(we2);
                oGo = int'(go2); oBusy = int'(busy2); oCf = int'(cf2);
            end
        endcase
    end

    function automatic int cfgW(input int c);
        return (c == 2) ? 2 : 4;
    endfunction

    function automatic int cfgH(input int c);
        return (c == 2) ? 1 : 3;
    endfunction

    function automatic int cfgP(input int c);
        return (c == 1) ? 3 : 1;
    endfunction

    function automatic int cfgPw(input int c);
        return (c == 2) ? 10 : 8;
    endfunction

    // Cycles from the start edge until the done flag is up.
    function automatic int frameLen(input int c);
        return (cfgW(c) * cfgH(c) - 1) * cfgP(c) + 3;
    endfunction

    // Reference pixel op, in plain arithmetic on the pixel's numeric value.
    function automatic int opModel(input int pw, input int md, input int th, input int p);
        int maxv;
        int pv;
        int tv;
        maxv = (1 << pw) - 1;
        pv = p & maxv;
        tv = th & maxv;
        case (md)
            1:       return maxv - pv;
            2:       return (pv >= tv) ? maxv : 0;
            default: return pv;
        endcase
    endfunction

    task automatic checkOutput(input string what, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", what, actual, expected);
        end
    endtask

    // Drive inputs for frame cycle k: optional stray starts, optional late
    // change of the op settings, and source data one cycle after each read.
    task automatic applyStimulus(input int k, input int p, input int n, input int chgK,
                                 input int sp1, input int sp2,
                                 input logic [1:0] md, input logic [15:0] th);
        start = (k == sp1) || (k == sp2);
        if (k == chgK) begin
            mode   = ~md;
            thresh = ~th;
        end
        if (k >= 1 && (k - 1) % p == 0 && (k - 1) / p < n) gin = pix[(k - 1) / p];
        else gin = 16'($urandom);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " read_enable"}, oRe, 0);
        checkOutput({name, " write_enable"}, oWe, 0);
        checkOutput({name, " gray_out"}, oGo, 0);
        checkOutput({name, " busy"}, oBusy, 0);
        checkOutput({name, " conv_finished"}, oCf, 0);
        checkOutput({name, " x_cnt"}, oX, 0);
        checkOutput({name, " y_cnt"}, oY, 0);
    endtask

    // Run one frame on instance c and compare every cycle against the timing
    // model: read i at cycle i*P, its write at i*P+2, done at (N-1)*P+3.
    task automatic runFrame(input string name, input int c, input logic [1:0] md,
                            input logic [15:0] th, input int chgK, input int sp1,
                            input int sp2, input int abortK);
        int w, p, n, len, idx, j;
        int eRe, eX, eY, eWe, eOut;
        w = cfgW(c);
        p = cfgP(c);
        n = w * cfgH(c);
        len = frameLen(c);
        sel = c;
        mode = md;
        thresh = th;
        @(posedge clk); #1;
        start = 1'b1;
        for (int k = 0; k <= len + 3; k++) begin
            @(posedge clk); #1;
            applyStimulus(k, p, n, chgK, sp1, sp2, md, th);
            @(negedge clk);
            eRe = (k % p == 0 && k / p < n) ? 1 : 0;
            idx = (k + p - 1) / p;
            eX = (idx < n) ? idx % w : 0;
            eY = (idx < n) ? idx / w : 0;
            eWe = (k >= 2 && (k - 2) % p == 0 && (k - 2) / p < n) ? 1 : 0;
            if (k >= 2) begin
                j = (k - 2) / p;
                if (j > n - 1) j = n - 1;
                eOut = int'(expOut[j]);
            end else begin
                eOut = lastOut[c];
            end
            checkOutput($sformatf("%s k=%0d read_enable", name, k), oRe, eRe);
            checkOutput($sformatf("%s k=%0d x_cnt", name, k), oX, eX);
            checkOutput($sformatf("%s k=%0d y_cnt", name, k), oY, eY);
            checkOutput($sformatf("%s k=%0d write_enable", name, k), oWe, eWe);
            checkOutput($sformatf("%s k=%0d gray_out", name, k), oGo, eOut);
            checkOutput($sformatf("%s k=%0d busy", name, k), oBusy, (k < len) ? 1 : 0);
            checkOutput($sformatf("%s k=%0d conv_finished", name, k), oCf, (k >= len) ? 1 : 0);
            if (k == abortK) begin
                start = 1'b0;
                return;
            end
        end
        start = 1'b0;
        lastOut[c] = int'(expOut[n - 1]);
    endtask

    // Main sequence: reset, directed frames, constant-pixel table, stray
    // starts, random frames, then a mid-frame reset and recovery.
    initial begin
        int n, c, pw, mask, len;
        logic [1:0] md;
        logic [15:0] th;
        logic [15:0] tpat [4];
        logic [15:0] tres [4];

        checks = 0;
        errors = 0;
        for (int i = 0; i < 3; i++) lastOut[i] = 0;

        vecs[0] = '{1, 2'd1, 16'h0000, 16'h0010, 16'h00EF};
        vecs[1] = '{0, 2'd2, 16'h0080, 16'h007F, 16'h0000};
        vecs[2] = '{0, 2'd2, 16'h0080, 16'h0080, 16'h00FF};
        vecs[3] = '{0, 2'd2, 16'h0080, 16'h00FF, 16'h00FF};
        vecs[4] = '{0, 2'd0, 16'h0000, 16'h00A5, 16'h00A5};
        vecs[5] = '{0, 2'd3, 16'h0000, 16'h005A, 16'h005A};
        vecs[6] = '{2, 2'd1, 16'h0000, 16'h0000, 16'h03FF};
        vecs[7] = '{2, 2'd2, 16'h0200, 16'h01FF, 16'h0000};
        vecs[8] = '{2, 2'd2, 16'h0200, 16'h0200, 16'h03FF};
        vecs[9] = '{1, 2'd1, 16'h0000, 16'h003C, 16'h00C3};

        tpat[0] = 16'h007F; tpat[1] = 16'h0080; tpat[2] = 16'h00FF; tpat[3] = 16'h0000;
        tres[0] = 16'h0000; tres[1] = 16'h00FF; tres[2] = 16'h00FF; tres[3] = 16'h0000;

        reset_n = 1'b1;
        start = 1'b0;
        sel = 0;
        mode = 2'd0;
        thresh = 16'h0;
        gin = 16'h0;
        #1 reset_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            @(negedge clk);
            checkAllZero($sformatf("reset inst%0d", s));
        end
        @(posedge clk); #1;
        reset_n = 1'b1;

        $display("[TB] ramp frame, pace 1, pass");
        for (int i = 0; i < 12; i++) begin
            pix[i] = 16'(i);
            expOut[i] = 16'(i);
        end
        runFrame("ramp", 0, 2'd0, 16'h0, -1, -1, -1, -1);

        $display("[TB] constant-pixel table");
        for (int v = 0; v < 10; v++) begin
            n = cfgW(vecs[v].cfg) * cfgH(vecs[v].cfg);
            for (int i = 0; i < n; i++) begin
                pix[i] = vecs[v].pin;
                expOut[i] = vecs[v].res;
            end
            runFrame($sformatf("vec%0d", v), vecs[v].cfg, vecs[v].md, vecs[v].th, -1, -1, -1, -1);
        end

        $display("[TB] threshold pattern with late settings change");
        for (int i = 0; i < 12; i++) begin
            pix[i] = tpat[i % 4];
            expOut[i] = tres[i % 4];
        end
        runFrame("thrLate", 0, 2'd2, 16'h0080, 5, -1, -1, -1);

        $display("[TB] stray starts during RUN, DRAIN and DONE entry");
        len = frameLen(1);
        for (int i = 0; i < 12; i++) begin
            pix[i] = 16'($urandom_range(0, 255));
            expOut[i] = 16'(opModel(8, 1, 0, int'(pix[i])));
        end
        runFrame("stray1", 1, 2'd1, 16'h0, -1, 10, len - 2, -1);
        runFrame("stray2", 1, 2'd1, 16'h0, -1, len - 1, -1, -1);
        runFrame("again", 1, 2'd1, 16'h0, -1, -1, -1, -1);

        $display("[TB] random frames");
        for (int r = 0; r < 8; r++) begin
            c = $urandom_range(0, 2);
            pw = cfgPw(c);
            mask = (1 << pw) - 1;
            md = 2'($urandom_range(0, 3));
            th = 16'($urandom & mask);
            n = cfgW(c) * cfgH(c);
            for (int i = 0; i < n; i++) begin
                pix[i] = 16'($urandom & mask);
                expOut[i] = 16'(opModel(pw, int'(md), int'(th), int'(pix[i])));
            end
            runFrame($sformatf("rand%0d", r), c, md, th, $urandom_range(1, 8), -1, -1, -1);
        end

        $display("[TB] reset after five reads");
        for (int i = 0; i < 12; i++) begin
            pix[i] = 16'($urandom_range(0, 255));
            expOut[i] = pix[i];
        end
        runFrame("abort", 1, 2'd0, 16'h0, -1, -1, -1, 13);
        #2 reset_n = 1'b0;
        #1;
        checkAllZero("async reset");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("in reset %0d read_enable", i), oRe, 0);
            checkOutput($sformatf("in reset %0d write_enable", i), oWe, 0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) lastOut[i] = 0;
        runFrame("recover", 1, 2'd0, 16'h0, -1, -1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
